// File: rtl/sw_debounce_pulse.sv
// sw_debounce_pulse: conditioning stage for the board's active-low push switches.
// Each channel is synchronised with two flops, debounced by a hold-time
// counter with a RELEASED/PRESSED state machine, and turned into a clean level
// plus one-cycle press and release strobes.
// Define AUTO_REPEAT_EN to add a typematic repeat strobe per channel. Without
// it, sw_repeat is tied low and no repeat counters exist.

module sw_debounce_pulse #(
   parameter int N_SW            = 3,
   parameter int DEBOUNCE_CYCLES = 12000,
   parameter int REPEAT_DELAY    = 6000000,
   parameter int REPEAT_RATE     = 1200000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] sw_n,
   output logic [N_SW-1:0] sw_level,
   output logic [N_SW-1:0] sw_press,
   output logic [N_SW-1:0] sw_release,
   output logic [N_SW-1:0] sw_repeat
);

   // The counter only has to reach DEBOUNCE_CYCLES-1, so it never wraps.
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } db_state_t;

   logic [N_SW-1:0]  r_sync1;
   logic [N_SW-1:0]  r_sync2;     // raw_s: synchronised, still active-low
   db_state_t        r_state     [N_SW];
   db_state_t        w_state_nxt [N_SW];
   logic [CNT_W-1:0] r_cnt       [N_SW];
   logic [CNT_W-1:0] w_cnt_nxt   [N_SW];
   logic [N_SW-1:0]  w_rise;
   logic [N_SW-1:0]  w_fall;
   logic [N_SW-1:0]  r_press;
   logic [N_SW-1:0]  r_release;

   // Two-flop synchroniser; reset to 1 so a reset looks like "all released".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         // NOTE: non-blocking assignments here let r_sync2 take the old
         // r_sync1; blocking ones would collapse the two stages into one.
         r_sync1 <= sw_n;
         r_sync2 <= r_sync1;
      end
   end

   // State register: debounce state and hold-time counter per channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SW; i++) begin
            r_state[i] <= RELEASED;
            r_cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_SW; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
      end
   end

   // Next state: count consecutive mismatching samples, flip on the last one.
   always_comb begin
      for (int i = 0; i < N_SW; i++) begin
         // NOTE: every output of this block gets a default first, so no path
         // leaves a value unassigned and no latch is inferred.
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = '0;
         w_rise[i]      = 1'b0;
         w_fall[i]      = 1'b0;
         if ((~r_sync2[i]) != (r_state[i] == PRESSED)) begin
            if (r_cnt[i] == CNT_LAST) begin
               w_state_nxt[i] = (r_state[i] == PRESSED) ? RELEASED : PRESSED;
               w_rise[i]      = (r_state[i] == RELEASED);
               w_fall[i]      = (r_state[i] == PRESSED);
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Strobes are registered on the same edge the state flips, so they line up with the level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_press   <= '0;
         r_release <= '0;
      end else begin
         r_press   <= w_rise;
         r_release <= w_fall;
      end
   end

   // Outputs: the level is a decode of the state flop; strobes come straight from flops.
   always_comb begin
      for (int i = 0; i < N_SW; i++) begin
         sw_level[i] = (r_state[i] == PRESSED);
      end
      sw_press   = r_press;
      sw_release = r_release;
   end

`ifdef AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE - 1);

   logic [REP_W-1:0] r_rep_cnt [N_SW];
   logic [N_SW-1:0]  r_rep_armed;   // set once the first (long) delay has elapsed
   logic [N_SW-1:0]  r_repeat;

   // Typematic timer: restarts on press, idles while released or releasing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SW; i++) begin
            r_rep_cnt[i] <= '0;
         end
         r_rep_armed <= '0;
         r_repeat    <= '0;
      end else begin
         for (int i = 0; i < N_SW; i++) begin
            if (r_state[i] != PRESSED || w_fall[i]) begin
               r_rep_cnt[i]   <= '0;
               r_rep_armed[i] <= 1'b0;
               r_repeat[i]    <= 1'b0;
            end else if (r_rep_cnt[i] == (r_rep_armed[i] ? REP_NEXT : REP_FIRST)) begin
               r_rep_cnt[i]   <= '0;
               r_rep_armed[i] <= 1'b1;
               r_repeat[i]    <= 1'b1;
            end else begin
               r_rep_cnt[i]   <= r_rep_cnt[i] + 1'b1;
               r_repeat[i]    <= 1'b0;
            end
         end
      end
   end

   assign sw_repeat = r_repeat;
`else
   logic w_unused_repeat_cfg;
   assign w_unused_repeat_cfg = |{REPEAT_DELAY, REPEAT_RATE};
   assign sw_repeat = '0;
`endif

endmodule

// File: tb/tb_sw_debounce_pulse.sv
// Testbench for sw_debounce_pulse with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=3. Table-driven per-cycle vectors plus a hand-written
// reset-in-the-middle sequence. Expected sw_repeat is derived from a small
// typematic model (all zero unless AUTO_REPEAT_EN is defined).

module tb_sw_debounce_pulse;

   localparam int N  = 3;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] sw_n = '1;
   logic [N-1:0] sw_level;
   logic [N-1:0] sw_press;
   logic [N-1:0] sw_release;
   logic [N-1:0] sw_repeat;

   int n_checks = 0;
   int n_errors = 0;
   int since [N];   // cycles since each channel's press strobe
   int row_no = 0;

   typedef struct {
      logic [N-1:0] sw_n;
      logic [N-1:0] lvl;
      logic [N-1:0] prs;
      logic [N-1:0] rel;
   } vec_t;

   vec_t tbl [$];

   sw_debounce_pulse #(
      .N_SW           (N),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_RATE    (RR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_n      (sw_n),
      .sw_level  (sw_level),
      .sw_press  (sw_press),
      .sw_release(sw_release),
      .sw_repeat (sw_repeat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add(input logic [N-1:0] s, input logic [N-1:0] l,
                      input logic [N-1:0] p, input logic [N-1:0] r, input int reps);
      vec_t v;
      v.sw_n = s; v.lvl = l; v.prs = p; v.rel = r;
      for (int k = 0; k < reps; k++) tbl.push_back(v);
   endtask

   // Drive one vector, clock one edge, compare all four outputs.
   task automatic apply(input vec_t v);
      logic [N-1:0] exp_rep;
      @(negedge clk);
      sw_n = v.sw_n;
      @(posedge clk);
      #1;
      row_no++;
      exp_rep = '0;
      for (int i = 0; i < N; i++) begin
         if (v.prs[i]) since[i] = 0;
         else if (v.lvl[i]) since[i]++;
`ifdef AUTO_REPEAT_EN
         exp_rep[i] = v.lvl[i] && !v.prs[i] && since[i] >= RD && ((since[i] - RD) % RR == 0);
`endif
      end
      check($sformatf("row%0d level", row_no),   sw_level,   v.lvl);
      check($sformatf("row%0d press", row_no),   sw_press,   v.prs);
      check($sformatf("row%0d release", row_no), sw_release, v.rel);
      check($sformatf("row%0d repeat", row_no),  sw_repeat,  exp_rep);
   endtask

   // Press on the first row, strobe DB+2 edges later, then one steady row.
   task automatic add_edge(input logic [N-1:0] s, input logic [N-1:0] old_l,
                           input logic [N-1:0] new_l, input logic [N-1:0] p,
                           input logic [N-1:0] r);
      add(s, old_l, 3'b000, 3'b000, DB + 1);
      add(s, new_l, p, r, 1);
      add(s, new_l, 3'b000, 3'b000, 1);
   endtask

   task automatic check_idle(input string name);
      check({name, " level"},   sw_level,   3'b000);
      check({name, " press"},   sw_press,   3'b000);
      check({name, " release"}, sw_release, 3'b000);
      check({name, " repeat"},  sw_repeat,  3'b000);
   endtask

   initial begin
      for (int i = 0; i < N; i++) since[i] = 0;

      // Main table, applied straight after the first reset release.
      add(3'b111, 3'b000, 3'b000, 3'b000, 2);              // idle
      add_edge(3'b110, 3'b000, 3'b001, 3'b001, 3'b000);    // ch0 press
      add(3'b100, 3'b001, 3'b000, 3'b000, 3);              // ch1 3-cycle glitch
      add(3'b110, 3'b001, 3'b000, 3'b000, 5);
      add(3'b100, 3'b001, 3'b000, 3'b000, 2);              // bounce 0,0,1,0...
      add(3'b110, 3'b001, 3'b000, 3'b000, 1);
      add_edge(3'b100, 3'b001, 3'b011, 3'b010, 3'b000);    // counted from last 1
      add_edge(3'b111, 3'b011, 3'b000, 3'b000, 3'b011);    // ch0+ch1 release
      add_edge(3'b010, 3'b000, 3'b101, 3'b101, 3'b000);    // ch0+ch2 same edge
      add_edge(3'b110, 3'b101, 3'b001, 3'b000, 3'b100);    // ch2 release
      add_edge(3'b111, 3'b001, 3'b000, 3'b000, 3'b001);    // ch0 release

      // Outputs are cleared while reset is held.
      #2;
      check_idle("reset");
      @(posedge clk);
      #3 rst = 1'b0;

      for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

      // Start a press on ch0, then reset mid-count with the switch still held.
      tbl.delete();
      add(3'b110, 3'b000, 3'b000, 3'b000, 3);
      for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_idle("async rst");
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1 check_idle($sformatf("in rst %0d", k));
      end
      @(posedge clk);
      #3 rst = 1'b0;

      // Fresh debounce from RELEASED, long hold for typematic repeat, release.
      tbl.delete();
      add_edge(3'b110, 3'b000, 3'b001, 3'b001, 3'b000);
      add(3'b110, 3'b001, 3'b000, 3'b000, 20);
      add_edge(3'b111, 3'b001, 3'b000, 3'b000, 3'b001);
      add(3'b111, 3'b000, 3'b000, 3'b000, 4);
      for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sw_debounce_pulse.md
Name: sw_debounce_pulse

Overview:
- Upstream conditioning stage for the board's active-low push switches, feeding the decimal up/down counter and display stage.
- Per switch: synchronises the raw input, debounces it with a hold-time counter, and produces a clean level, one-cycle press/release strobes and an optional typematic repeat strobe.
- The counter stage then acts on single-cycle events instead of polling raw switch levels.

Parameters:
- N_SW, 3, number of switch channels (sw_n[0]=SW_1 up, [1]=SW_2 down, [2]=SW_3 clear).
- DEBOUNCE_CYCLES, 12000, consecutive cycles a new raw level must persist before it is accepted; legal range >=2.
- REPEAT_DELAY, 6000000, cycles from press strobe to first repeat strobe (repeat feature only); >=1.
- REPEAT_RATE, 1200000, cycles between subsequent repeat strobes (repeat feature only); >=1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sw_n  in  N_SW  raw switch inputs, active-low (0 = pressed), asynchronous to clk
- sw_level  out  N_SW  debounced state, active-high (1 = pressed)
- sw_press  out  N_SW  one-cycle strobe on accepted press
- sw_release  out  N_SW  one-cycle strobe on accepted release
- sw_repeat  out  N_SW  one-cycle typematic strobe while held (optional feature)

Behaviour:
- Reset (async assert, sync release):
  - Sync flops = 1 (released); debounce and repeat counters = 0; stable state = released.
  - sw_level, sw_press, sw_release and sw_repeat all = 0.
- Synchroniser: 2 flops per channel; all logic below uses the stage-2 output (raw_s, active-low).
- Per-channel debounce, 2-state machine {RELEASED, PRESSED}:
  - If raw_s matches the current state, the counter clears to 0.
  - If raw_s differs, the counter increments. When the counter equals DEBOUNCE_CYCLES-1 while raw_s still differs, the state flips and the counter clears.
  - Any mismatch gap of even one cycle restarts the count from 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it never wraps.
- Outputs registered:
  - sw_level = (state==PRESSED).
  - sw_press is asserted in the same cycle sw_level rises; sw_release in the same cycle sw_level falls. Each lasts exactly 1 cycle.
- Latency: DEBOUNCE_CYCLES+2 clock edges from the first edge sampling the new sw_n level to the sw_level/strobe change.
- Glitch rejection: a pulse on sw_n shorter than DEBOUNCE_CYCLES cycles produces no strobe and no level change.
- Channels are fully independent; simultaneous presses on several channels give simultaneous strobes. Priority between up/down/clear belongs to the consumer.
- Reset mid-operation:
  - Counts in progress are discarded.
  - A switch held through reset release is debounced from RELEASED and yields a normal sw_press after DEBOUNCE_CYCLES+2 edges.
- No strobe is ever generated while rst is high.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined:
  - Each channel has a repeat counter that clears on sw_press and counts while state==PRESSED.
  - First sw_repeat pulse fires REPEAT_DELAY cycles after the sw_press cycle; further pulses follow every REPEAT_RATE cycles while held.
  - Release clears the counter immediately; no sw_repeat in or after the sw_release cycle.
  - sw_repeat never coincides with sw_press.
- Undefined: sw_repeat tied to 0 and no repeat counters are synthesised. All other behaviour is identical.

Test Plan:
- DEBOUNCE_CYCLES=4: after reset, hold sw_n[0]=0 -> sw_press[0]=1 for one cycle exactly 6 edges later, sw_level[0]=1 from then on; other channels stay 0.
- DEBOUNCE_CYCLES=4: drive sw_n[1] low for 3 cycles, then high -> no sw_press[1], sw_level[1] stays 0. Bounce pattern 0,0,1,0,0,0,0 -> a single press strobe, counted from the last 1.
- Pressed channel 2 (DEBOUNCE_CYCLES=4): release sw_n[2]=1 -> sw_release[2] for one cycle 6 edges later, sw_level[2]=0.
- Press sw_n[0] and sw_n[2] on the same edge -> sw_press[0] and sw_press[2] on the same cycle.
- Hold sw_n[0]=0 across an async rst pulse mid-count, then deassert rst -> outputs 0 during reset; one sw_press[0] 6 edges after the first post-reset sampling edge.
- AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_RATE=3: hold 20 cycles after press -> sw_repeat at press+10, +13, +16, +19. Release -> no further repeats. Without the macro -> sw_repeat constant 0.
